// File: rtl/disp_cmd_defs_pkg.sv
// rtl/disp_cmd_defs_pkg.sv - shared definitions for the display command FIFO writer
package disp_cmd_defs;

  localparam int CMD_W  = 8;
  localparam int TICK_W = 8;

  localparam logic [CMD_W-1:0] RST_DATA = 8'h00;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    WR_RECOVER
  } wr_state_t;

  // A phase lasting N cycles counts down from N-1 to 0.
  function automatic logic [TICK_W-1:0] tick_load(input int ticks);
    return TICK_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/disp_cmd_writer_queue.sv
// rtl/disp_cmd_writer_queue.sv - QDEPTH x CMD_W circular command queue
module cmd_queue
  import disp_cmd_defs::*;
#(
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_push_data,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int AW = $clog2(QDEPTH);

  logic [CMD_W-1:0] r_mem [QDEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // QDEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(QDEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/disp_cmd_writer.sv
// rtl/disp_cmd_writer.sv - writes queued command bytes into the display byte FIFO
// Optional wr_count/stall_count statistics with `define DISP_CMD_WR_STATS_EN.
module disp_cmd_writer
  import disp_cmd_defs::*;
#(
  parameter int QDEPTH        = 4,
  parameter int SETUP_TICKS   = 1,
  parameter int STROBE_TICKS  = 2,
  parameter int HOLD_TICKS    = 1,
  parameter int RECOVER_TICKS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CMD_W-1:0] i_cmd_data,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  output logic [CMD_W-1:0] o_fifo_data,
  output logic             o_fifo_nwr,
  input  logic             i_fifo_nff_in,
  output logic             o_busy
`ifdef DISP_CMD_WR_STATS_EN
  ,
  output logic [15:0]      o_wr_count,
  output logic [15:0]      o_stall_count
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  localparam logic [TICK_W-1:0] SETUP_LD   = tick_load(SETUP_TICKS);
  localparam logic [TICK_W-1:0] STROBE_LD  = tick_load(STROBE_TICKS);
  localparam logic [TICK_W-1:0] HOLD_LD    = tick_load(HOLD_TICKS);
  localparam logic [TICK_W-1:0] RECOVER_LD = tick_load(RECOVER_TICKS);

  wr_state_t         r_state;
  wr_state_t         w_state_nxt;
  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_tick_nxt;
  logic              r_nwr;
  logic [CMD_W-1:0]  r_fifo_data;
  logic              r_cmd_ready;
  logic              r_nff_s1;
  logic              r_nff_s2;

  logic              w_push;
  logic              w_pop;
  logic [CMD_W-1:0]  w_q_head;
  logic              w_q_full;
  logic              w_q_empty;
  logic [CW-1:0]     w_q_count;
  logic [CW-1:0]     w_count_nxt;

  cmd_queue #(
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (i_cmd_data),
    .i_pop       (w_pop),
    .o_head      (w_q_head),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_count     (w_q_count)
  );

  assign w_push = i_cmd_valid & r_cmd_ready & ~w_q_full;

  // The full flag is asynchronous to clk; only the second stage is used.
  always_ff @(posedge i_clk) begin
    r_nff_s1 <= i_fifo_nff_in;
    r_nff_s2 <= r_nff_s1;
  end

  always_comb begin
    w_count_nxt = w_q_count;
    if (w_push && !w_pop) begin
      w_count_nxt = w_q_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = w_q_count - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_pop       = 1'b0;
    case (r_state)
      WR_IDLE: begin
        if (!w_q_empty && r_nff_s2) begin
          w_pop       = 1'b1;
          w_state_nxt = WR_SETUP;
          w_tick_nxt  = SETUP_LD;
        end
      end
      WR_SETUP: begin
        if (r_tick == '0) begin
          w_state_nxt = WR_STROBE;
          w_tick_nxt  = STROBE_LD;
        end else begin
          w_tick_nxt = r_tick - 1'b1;
        end
      end
      WR_STROBE: begin
        if (r_tick == '0) begin
          w_state_nxt = WR_HOLD;
          w_tick_nxt  = HOLD_LD;
        end else begin
          w_tick_nxt = r_tick - 1'b1;
        end
      end
      WR_HOLD: begin
        if (r_tick == '0) begin
          w_state_nxt = WR_RECOVER;
          w_tick_nxt  = RECOVER_LD;
        end else begin
          w_tick_nxt = r_tick - 1'b1;
        end
      end
      WR_RECOVER: begin
        if (r_tick == '0) begin
          w_state_nxt = WR_IDLE;
        end else begin
          w_tick_nxt = r_tick - 1'b1;
        end
      end
      default: begin
        w_state_nxt = WR_IDLE;
        w_tick_nxt  = '0;
      end
    endcase
  end

  // Strobe and ready are registered so the FIFO and upstream never see decode glitches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= WR_IDLE;
      r_tick      <= '0;
      r_nwr       <= 1'b1;
      r_fifo_data <= RST_DATA;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_nwr       <= (w_state_nxt != WR_STROBE);
      r_cmd_ready <= (w_count_nxt != CW'(QDEPTH));
      if (w_pop) begin
        r_fifo_data <= w_q_head;
      end
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_fifo_data = r_fifo_data;
  assign o_fifo_nwr  = r_nwr;
  assign o_busy      = (r_state != WR_IDLE) | ~w_q_empty;

`ifdef DISP_CMD_WR_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_stall_count;
  logic        w_wr_done;
  logic        w_stall;

  assign w_wr_done = (r_state == WR_STROBE) && (r_tick == '0);
  assign w_stall   = (r_state == WR_IDLE) && !w_q_empty && !r_nff_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_wr_done && r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_stall && r_stall_count != 16'hFFFF) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign o_wr_count    = r_wr_count;
  assign o_stall_count = r_stall_count;
`endif

endmodule
